// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ requesters.
// Latches the winner's byte and parity setup, strobes the TX, then tracks tx_busy.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int START_TIMEOUT = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_par_en,
    input  logic [NUM_REQ-1:0]            req_par_typ,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [DATA_WIDTH-1:0]         tx_p_data,
    output logic                          tx_data_valid,
    output logic                          tx_par_en,
    output logic                          tx_par_typ,
    input  logic                          tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          arb_busy,
    output logic                          timeout_err
);
    localparam int ID_W = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_ISSUE      = 2'd1;
    localparam logic [1:0] S_WAIT_START = 2'd2;
    localparam logic [1:0] S_WAIT_DONE  = 2'd3;

    logic [1:0]      state;
    logic [ID_W-1:0] ptr;
    logic [3:0]      cnt;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] idx;
    logic            found;
    logic            start_expired;

    // First valid requester scanning upward from the slot after the last winner.
    always_comb begin
        win   = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign start_expired = (cnt == 4'(START_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            ptr        <= ID_W'(NUM_REQ - 1);
            cnt        <= 4'd0;
            tx_p_data  <= '0;
            tx_par_en  <= 1'b0;
            tx_par_typ <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found && !tx_busy) begin
                        state      <= S_ISSUE;
                        ptr        <= win;
                        tx_p_data  <= req_data[win*DATA_WIDTH +: DATA_WIDTH];
                        tx_par_en  <= req_par_en[win];
                        tx_par_typ <= req_par_typ[win];
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT_START;
                    cnt   <= 4'd0;
                end
                S_WAIT_START: begin
                    if (tx_busy)
                        state <= S_WAIT_DONE;
                    else if (start_expired)
                        state <= S_IDLE;
                    else
                        cnt <= cnt + 4'd1;
                end
                S_WAIT_DONE: begin
                    if (!tx_busy)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobe, ack and error are decoded from state so a reset edge clears them at once.
    assign tx_data_valid = (state == S_ISSUE);
    assign req_ack       = (state == S_ISSUE) ? (NUM_REQ'(1) << ptr) : '0;
    assign grant_id      = ptr;
    assign arb_busy      = (state != S_IDLE);
    assign timeout_err   = (state == S_WAIT_START) && !tx_busy && start_expired;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a frame-level reference model checked every
// cycle, plus hand-computed expectations for order, spacing, timeout and reset.
module tb_uart_tx_arbiter;
    localparam int N        = 4;
    localparam int DW       = 8;
    localparam int TO       = 4;
    localparam int BUSY_LEN = 10;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_par_en = '0;
    logic [N-1:0]    req_par_typ = '0;
    logic [N-1:0]    req_ack;
    logic [DW-1:0]   tx_p_data;
    logic            tx_data_valid;
    logic            tx_par_en;
    logic            tx_par_typ;
    logic            tx_busy;
    logic [1:0]      grant_id;
    logic            arb_busy;
    logic            timeout_err;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .START_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data),
        .req_par_en(req_par_en), .req_par_typ(req_par_typ),
        .req_ack(req_ack), .tx_p_data(tx_p_data), .tx_data_valid(tx_data_valid),
        .tx_par_en(tx_par_en), .tx_par_typ(tx_par_typ), .tx_busy(tx_busy),
        .grant_id(grant_id), .arb_busy(arb_busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int n_acks  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter stand-in: takes the strobe at the next edge, then stays busy BUSY_LEN cycles.
    int   tx_cnt = 0;
    logic tx_en = 1'b1;
    logic tx_force = 1'b0;
    always @(posedge clk) begin
        if (tx_en && tx_data_valid) tx_cnt <= BUSY_LEN;
        else if (tx_cnt > 0)        tx_cnt <= tx_cnt - 1;
    end
    assign tx_busy = tx_force || (tx_cnt > 0);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic bound_fail(input string name);
        n_total++;
        $display("FAIL %s: event did not occur within the cycle budget (cycle %0d)", name, cyc);
    endtask

    // Frame-level model: a frame is either absent or in flight with an age since its grant.
    bit        m_known = 0;
    bit        m_active = 0;
    bit        m_started = 0;
    int        m_age = 0;
    int        m_ptr = N - 1;
    logic [7:0] m_data = '0;
    bit        m_pe = 0;
    bit        m_pt = 0;

    always @(posedge clk) begin
        if (!reset) begin
            m_known = 1; m_active = 0; m_started = 0; m_age = 0;
            m_ptr = N - 1; m_data = '0; m_pe = 0; m_pt = 0;
        end else if (!m_active) begin
            if (req_valid != '0 && !tx_busy) begin
                for (int k = 1; k <= N; k++) begin
                    if (req_valid[(m_ptr + k) % N]) begin
                        m_ptr = (m_ptr + k) % N;
                        break;
                    end
                end
                m_data = req_data[m_ptr*DW +: DW];
                m_pe = req_par_en[m_ptr];
                m_pt = req_par_typ[m_ptr];
                m_active = 1; m_age = 1; m_started = 0;
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (!m_started) begin
            if (tx_busy)            m_started = 1;
            else if (m_age == TO+1) m_active = 0;
            else                    m_age++;
        end else if (!tx_busy) begin
            m_active = 0;
        end
    end

    logic [N-1:0] e_ack;
    logic         e_dv, e_to;
    always @(negedge clk) begin
        if (m_known) begin
            e_dv  = m_active && (m_age == 1);
            e_ack = e_dv ? (N'(1) << m_ptr) : '0;
            e_to  = m_active && !m_started && (m_age == TO+1) && !tx_busy;
            check("model",
                  {13'd0, req_ack, tx_data_valid, tx_p_data, tx_par_en, tx_par_typ, grant_id, arb_busy, timeout_err},
                  {13'd0, e_ack, e_dv, m_data, m_pe, m_pt, 2'(m_ptr), m_active, e_to});
            n_acks += $countones(req_ack);
        end
    end

    task automatic wait_strobe(output int gid, output int at);
        gid = -1; at = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tx_data_valid === 1'b1) begin
                gid = int'(grant_id); at = cyc;
                break;
            end
        end
        if (gid < 0) bound_fail("strobe_wait");
    endtask

    task automatic wait_busy(input logic level, input string name);
        bit ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tx_busy === level) begin ok = 1; break; end
        end
        if (!ok) bound_fail(name);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (arb_busy === 1'b0 && tx_busy === 1'b0) begin ok = 1; break; end
        end
        if (!ok) bound_fail("idle_wait");
    endtask

    task automatic pulse_reset();
        @(negedge clk); #1 reset = 1'b0;
        @(negedge clk); #1 reset = 1'b1;
    endtask

    int g, at, prev, base, first, nto, s2, g2, nstb;
    int ord [5] = '{0, 1, 2, 3, 0};
    bit busy_after_to;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_grant", grant_id, 2'd3);
        check("rst_data", tx_p_data, 8'h00);
        check("rst_flags", {req_ack, tx_data_valid, arb_busy, timeout_err, tx_par_en, tx_par_typ}, '0);
        #1 reset = 1'b1;

        // Single requester 2, byte A5, even parity
        req_data[2*DW +: DW] = 8'hA5; req_par_en = 4'b0100; req_par_typ = 4'b0000;
        req_valid = 4'b0100;
        wait_strobe(g, at);
        check("t1_ack", req_ack, 4'b0100);
        check("t1_data", tx_p_data, 8'hA5);
        check("t1_par", {tx_par_en, tx_par_typ}, 2'b10);
        check("t1_grant", g, 2);
        #1 req_valid = '0;
        wait_busy(1'b1, "t1_busy_rise");
        wait_busy(1'b0, "t1_busy_fall");
        check("t1_arb_busy_hold", arb_busy, 1'b1);
        @(negedge clk);
        check("t1_arb_busy_fall", arb_busy, 1'b0);

        // All four requesting continuously after a fresh reset
        pulse_reset();
        req_data = {8'h43, 8'h32, 8'h21, 8'h10};
        req_par_en = 4'b1010; req_par_typ = 4'b0110;
        base = n_acks;
        req_valid = 4'b1111;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            wait_strobe(g, at);
            check($sformatf("t2_order%0d", i), g, ord[i]);
            // issue + busy cycles + one WAIT_DONE cycle seeing busy low + one IDLE cycle
            if (i > 0) check($sformatf("t2_spacing%0d", i), at - prev, BUSY_LEN + 3);
            prev = at;
        end
        #1 req_valid = '0;
        wait_idle();
        check("t2_ack_count", n_acks - base, 5);

        // Wrap-around: 3, then with 1 and 3 valid -> 1, 3
        req_valid = 4'b1000;
        wait_strobe(g, at);
        check("t3_first", g, 3);
        #1 req_valid = 4'b1010;
        wait_strobe(g, at);
        check("t3_wrap", g, 1);
        #1 req_valid = 4'b1000;
        wait_strobe(g, at);
        check("t3_last", g, 3);
        #1 req_valid = '0;
        wait_idle();

        // Timeout: transmitter ignores the strobe; requester 2 waits its turn
        tx_en = 1'b0;
        req_valid = 4'b0110;
        wait_strobe(g, at);
        check("t4_grant", g, 1);
        #1 req_valid = 4'b0100;
        first = -1; nto = 0; s2 = -1; g2 = -1; busy_after_to = 1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == first + 1) busy_after_to = arb_busy;
            if (timeout_err === 1'b1) begin
                if (first < 0) first = k;
                nto++;
                tx_en = 1'b1;
            end
            if (tx_data_valid === 1'b1 && s2 < 0) begin s2 = k; g2 = int'(grant_id); end
        end
        check("t4_to_delay", first, 4);
        check("t4_to_once", nto, 1);
        check("t4_idle_after_to", busy_after_to, 1'b0);
        check("t4_next_strobe", s2, 6);
        check("t4_next_grant", g2, 2);
        req_valid = '0;
        wait_idle();

        // tx_busy high in IDLE blocks the grant; withdrawal after ack leaves data alone
        #1 tx_force = 1'b1;
        req_data[0 +: DW] = 8'h5C; req_par_en = 4'b0001; req_par_typ = 4'b0001;
        req_valid = 4'b0001;
        nstb = 0;
        repeat (5) begin
            @(negedge clk);
            if (tx_data_valid === 1'b1 || arb_busy === 1'b1) nstb++;
        end
        check("t5_no_grant_busy", nstb, 0);
        #1 tx_force = 1'b0;
        wait_strobe(g, at);
        check("t5_grant", g, 0);
        #1 req_valid = '0; req_data[0 +: DW] = 8'hFF; req_par_en = '0; req_par_typ = '0;
        wait_busy(1'b1, "t5_busy_rise");
        wait_busy(1'b0, "t5_busy_fall");
        check("t5_data_held", {tx_p_data, tx_par_en, tx_par_typ}, {8'h5C, 2'b11});
        wait_idle();

        // Reset while in WAIT_DONE, then requester 0 wins once the TX drains
        req_data[1*DW +: DW] = 8'h77;
        req_valid = 4'b0010;
        wait_strobe(g, at);
        #1 req_valid = '0;
        repeat (4) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t6_rst_outputs",
              {req_ack, tx_data_valid, arb_busy, timeout_err, tx_par_en, tx_par_typ, tx_p_data, grant_id},
              {4'b0, 5'b0, 8'h00, 2'd3});
        check("t6_tx_still_busy", tx_busy, 1'b1);
        #1 reset = 1'b1; req_valid = 4'b0101;
        wait_strobe(g, at);
        check("t6_grant0", g, 0);
        check("t6_tx_idle_at_grant", tx_busy, 1'b0);
        #1 req_valid = '0;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
